// File: rtl/snn_input_loader_if.sv
// Signal bundle between the SNN input loader and its neighbours: the UART receiver,
// the SNN core and the input-unit RAM. The loader itself uses the master modport.
interface snn_input_loader_if #(
    parameter int ADDR_W = 10
);
    // Handshake: rx_rdy and core_done are single-cycle valid strobes with no ready or
    // back-pressure; their data (rx_data, core_digit) is valid only in that cycle.
    // core_start and result_vld are likewise one-cycle strobes. ram_we qualifies ram_addr/ram_d.
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] core_addr;
    logic              core_done;
    logic [3:0]        core_digit;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_d;
    logic              ram_we;
    logic              core_start;
    logic              busy;
    logic [3:0]        result;
    logic              result_vld;
    logic              ovr;
    logic [2:0]        dbg_state;

    modport master (
        input  rx_rdy, rx_data, core_addr, core_done, core_digit,
        output ram_addr, ram_d, ram_we, core_start, busy, result, result_vld, ovr, dbg_state
    );

    modport slave (
        output rx_rdy, rx_data, core_addr, core_done, core_digit,
        input  ram_addr, ram_d, ram_we, core_start, busy, result, result_vld, ovr, dbg_state
    );
endinterface

// File: rtl/snn_input_loader.sv
// Unpacks a byte-packed binary image into 1-bit input-RAM writes, starts the SNN core,
// and latches the classified digit. Owns the input-RAM address mux.
module snn_input_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    snn_input_loader_if.master  lif
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UNPACK    = 3'd1,
        S_WAIT_BYTE = 3'd2,
        S_START     = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        shift;
    logic [7:0]        hold;
    logic              hold_full;
    logic [ADDR_W-1:0] pix_ptr;
    logic [2:0]        bit_cnt;
    logic              ovr;
    logic [3:0]        result;
    logic              result_vld;

    logic              byte_end;
    logic              image_end;
    logic              load_rx;
    logic              drain;
    logic              hold_take;
    logic              hold_flush;
    logic              drop;
    logic              latch;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_d;
    logic              core_start;

    assign byte_end  = (bit_cnt == 3'd7);
    assign image_end = (pix_ptr == LAST_PIX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ram_addr   = pix_ptr;
        ram_we     = 1'b0;
        ram_d      = 1'b0;
        core_start = 1'b0;
        load_rx    = 1'b0;
        drain      = 1'b0;
        hold_take  = 1'b0;
        hold_flush = 1'b0;
        drop       = 1'b0;
        latch      = 1'b0;
        case (state)
            S_IDLE: begin
                if (lif.rx_rdy) begin
                    load_rx   = 1'b1;
                    state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: begin
                ram_we = 1'b1;
                ram_d  = shift[0];
                if (byte_end && image_end) begin
                    // Anything arriving now, or still parked in hold, belongs to no image.
                    state_nxt  = S_START;
                    hold_flush = 1'b1;
                    drop       = lif.rx_rdy | hold_full;
                end else if (byte_end) begin
                    if (hold_full) begin
                        drain     = 1'b1;
                        hold_take = lif.rx_rdy;
                    end else if (lif.rx_rdy) begin
                        load_rx = 1'b1;
                    end else begin
                        state_nxt = S_WAIT_BYTE;
                    end
                end else if (lif.rx_rdy) begin
                    if (hold_full) begin
                        drop = 1'b1;
                    end else begin
                        hold_take = 1'b1;
                    end
                end
            end
            S_WAIT_BYTE: begin
                if (lif.rx_rdy) begin
                    load_rx   = 1'b1;
                    state_nxt = S_UNPACK;
                end
            end
            S_START: begin
                ram_addr   = lif.core_addr;
                core_start = 1'b1;
                drop       = lif.rx_rdy;
                state_nxt  = S_RUN;
            end
            S_RUN: begin
                ram_addr = lif.core_addr;
                drop     = lif.rx_rdy;
                if (lif.core_done) begin
                    latch     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= 8'd0;
            hold       <= 8'd0;
            hold_full  <= 1'b0;
            pix_ptr    <= '0;
            bit_cnt    <= 3'd0;
            ovr        <= 1'b0;
            result     <= 4'd0;
            result_vld <= 1'b0;
        end else begin
            result_vld <= 1'b0;

            if (load_rx) begin
                shift <= lif.rx_data;
            end else if (drain) begin
                shift <= hold;
            end else if (state == S_UNPACK) begin
                shift <= {1'b0, shift[7:1]};
            end

            // A byte taken on the drain cycle refills the buffer, so take wins over clear.
            if (hold_take) begin
                hold      <= lif.rx_data;
                hold_full <= 1'b1;
            end else if (drain || hold_flush) begin
                hold_full <= 1'b0;
            end

            if (state == S_UNPACK) begin
                bit_cnt <= bit_cnt + 3'd1;
            end else begin
                bit_cnt <= 3'd0;
            end

            if (state == S_START) begin
                pix_ptr <= '0;
            end else if (state == S_UNPACK && !image_end) begin
                pix_ptr <= pix_ptr + 1'b1;
            end

            if (drop) begin
                ovr <= 1'b1;
            end

            if (latch) begin
                result     <= lif.core_digit;
                result_vld <= 1'b1;
            end
        end
    end

    assign lif.ram_addr   = ram_addr;
    assign lif.ram_we     = ram_we;
    assign lif.ram_d      = ram_d;
    assign lif.core_start = core_start;
    assign lif.busy       = (state != S_IDLE);
    assign lif.result     = result;
    assign lif.result_vld = result_vld;
    assign lif.ovr        = ovr;
    assign lif.dbg_state  = state;
endmodule
